// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//
// Shares one physical-memory port between an I-cache and a D-cache. Each
// transaction is granted to one client and runs until the memory raises
// pmem_resp. Contention is resolved by alternating against the client that
// was served last.
//
// Parameters
//   LINE_W : cacheline width in bits (default 256)
//   ADDR_W : physical address width in bits (default 32)
//
// Ports
//   clk, rst               : clock (rising edge), asynchronous active-high reset
//   i_pmem_read/write      : I-cache line read / write request
//   i_pmem_address/wdata   : I-cache line address / write line
//   i_pmem_rdata/resp      : read line and done pulse back to the I-cache
//   d_pmem_*               : same set of signals for the D-cache
//   pmem_read/write        : command to shared physical memory
//   pmem_address/wdata     : address / write line to shared memory
//   pmem_rdata/resp        : read line / done pulse from shared memory
// ---------------------------------------------------------------------------
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // 0 = I-cache was served last, 1 = D-cache was served last.
  logic last_served_reg;
  logic last_served_next;

  logic i_req;
  logic d_req;

  assign i_req = i_pmem_read | i_pmem_write;
  assign d_req = d_pmem_read | d_pmem_write;

  // Read data is broadcast; each client qualifies it with its own resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_served_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_served_reg <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_served_next = last_served_reg;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    i_pmem_resp      = 1'b0;
    d_pmem_resp      = 1'b0;

    case (state_reg)
      IDLE: begin
        // Memory responses seen here are stray and deliberately ignored.
        if (i_req && d_req) begin
          // Contention: give the port to whoever did not go last.
          state_next = last_served_reg ? SERVE_I : SERVE_D;
        end else if (i_req) begin
          state_next = SERVE_I;
        end else if (d_req) begin
          state_next = SERVE_D;
        end
      end

      SERVE_I: begin
        // Write takes priority if the client raises both commands.
        pmem_write   = i_pmem_write;
        pmem_read    = i_pmem_read & ~i_pmem_write;
        pmem_address = i_pmem_address;
        pmem_wdata   = i_pmem_wdata;
        if (pmem_resp) begin
          i_pmem_resp      = 1'b1;
          state_next       = IDLE;
          last_served_next = 1'b0;
        end
      end

      SERVE_D: begin
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        if (pmem_resp) begin
          d_pmem_resp      = 1'b1;
          state_next       = IDLE;
          last_served_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
//
// Directed scenarios first (reset, single read, contention and alternation,
// D write, stray memory response, reset mid-transaction, read+write on one
// client), then a randomized phase: two client drivers and a memory model
// push each issued transaction into a per-client queue, while a monitor on
// the falling edge checks grants, bubbles and responses against those queues.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              i_pmem_read, i_pmem_write;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_wdata, i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read, d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata, d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
  logic              pmem_resp;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_write   (i_pmem_write),
    .i_pmem_address (i_pmem_address),
    .i_pmem_wdata   (i_pmem_wdata),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              exp_write;
    logic              exp_read;
  } txn_t;

  txn_t q_i[$];
  txn_t q_d[$];

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_pmem_read"},  pmem_read,    0);
    chk({pfx, "_pmem_write"}, pmem_write,   0);
    chk({pfx, "_pmem_addr"},  pmem_address, 0);
    chk({pfx, "_pmem_wdata"}, pmem_wdata,   0);
    chk({pfx, "_i_resp"},     i_pmem_resp,  0);
    chk({pfx, "_d_resp"},     d_pmem_resp,  0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic sb_on     = 1'b0;
  logic m_last_d  = 1'b0;   // reference: client served most recently (1 = D)
  logic m_cur_d   = 1'b0;   // client the current grant belongs to
  logic m_prev_cmd  = 1'b0;
  logic m_prev_ireq = 1'b0;
  logic m_prev_dreq = 1'b0;
  logic m_prev_resp = 1'b0;
  logic m_cmd, m_who, m_exp_d;
  txn_t mt;

  always @(negedge clk) begin
    if (sb_on) begin
      m_cmd = pmem_read | pmem_write;

      // A new grant: decided by who was waiting in the preceding idle cycle.
      if (m_cmd && !m_prev_cmd) begin
        chk("grant_had_request", m_prev_ireq | m_prev_dreq, 1);
        m_exp_d = m_prev_dreq && (!m_prev_ireq || !m_last_d);
        m_cur_d = m_exp_d;
        if (m_exp_d ? (q_d.size() == 0) : (q_i.size() == 0)) begin
          chk("grant_queue_size", m_exp_d ? q_d.size() : q_i.size(), 1);
        end else begin
          mt = m_exp_d ? q_d[0] : q_i[0];
          chk("grant_addr",  pmem_address, mt.addr);
          chk("grant_write", pmem_write,   mt.exp_write);
          chk("grant_read",  pmem_read,    mt.exp_read);
        end
      end

      if (i_pmem_resp || d_pmem_resp) begin
        chk("single_resp", i_pmem_resp & d_pmem_resp, 0);
        chk("resp_with_pmem_resp", pmem_resp, 1);
        m_who = d_pmem_resp;
        chk("resp_client", m_who, m_cur_d);
        if (m_who ? (q_d.size() == 0) : (q_i.size() == 0)) begin
          chk("resp_queue_size", m_who ? q_d.size() : q_i.size(), 1);
        end else begin
          mt = m_who ? q_d.pop_front() : q_i.pop_front();
          chk("resp_addr",  pmem_address, mt.addr);
          chk("resp_write", pmem_write,   mt.exp_write);
          chk("resp_read",  pmem_read,    mt.exp_read);
          chk("resp_wdata", pmem_wdata,   mt.wdata);
          chk("resp_rdata", m_who ? d_pmem_rdata : i_pmem_rdata, pmem_rdata);
          $display("txn client=%s addr=%h write=%0d", m_who ? "D" : "I", mt.addr, mt.exp_write);
        end
        m_last_d = m_who;
      end

      if (pmem_resp && !m_cmd) begin
        chk("stray_i_resp", i_pmem_resp, 0);
        chk("stray_d_resp", d_pmem_resp, 0);
      end

      if (m_prev_resp) chk("bubble_after_resp", m_cmd, 0);

      m_prev_cmd  = m_cmd;
      m_prev_ireq = i_pmem_read | i_pmem_write;
      m_prev_dreq = d_pmem_read | d_pmem_write;
      m_prev_resp = i_pmem_resp | d_pmem_resp;
    end
  end

  // ---------------- random stimulus ----------------
  logic act_i = 1'b0, act_d = 1'b0;
  logic mem_busy = 1'b0;
  int   mem_cnt = 0;
  logic o_i, o_d, o_cmd, o_any;

  function automatic txn_t new_txn(input logic is_d, output logic rd, output logic wr);
    txn_t t;
    int kind;
    kind        = $urandom_range(0, 2);   // 0 read, 1 write, 2 both raised
    wr          = (kind != 0);
    rd          = (kind != 1);
    t.addr      = $urandom;
    t.addr[31]  = is_d;
    t.addr[5:0] = 6'd0;
    t.wdata     = rand_line();
    t.exp_write = wr;
    t.exp_read  = rd && !wr;
    return t;
  endfunction

  task automatic rand_cycle(input bit allow_new);
    txn_t t;
    logic rd, wr;
    @(negedge clk);
    o_i   = i_pmem_resp;
    o_d   = d_pmem_resp;
    o_cmd = pmem_read | pmem_write;
    o_any = act_i | act_d;
    step();
    // Clients hold their request until their resp is seen.
    if (act_i && o_i) begin
      act_i = 1'b0; i_pmem_read = 1'b0; i_pmem_write = 1'b0;
    end else if (!act_i && allow_new && $urandom_range(0, 3) == 0) begin
      t = new_txn(1'b0, rd, wr);
      q_i.push_back(t);
      act_i = 1'b1; i_pmem_read = rd; i_pmem_write = wr;
      i_pmem_address = t.addr; i_pmem_wdata = t.wdata;
    end
    if (act_d && o_d) begin
      act_d = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    end else if (!act_d && allow_new && $urandom_range(0, 3) == 0) begin
      t = new_txn(1'b1, rd, wr);
      q_d.push_back(t);
      act_d = 1'b1; d_pmem_read = rd; d_pmem_write = wr;
      d_pmem_address = t.addr; d_pmem_wdata = t.wdata;
    end
    // Memory: random latency per command, occasional stray pulse when idle.
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_busy  = 1'b0;
    end else begin
      if (!mem_busy && o_cmd) begin
        mem_busy = 1'b1;
        mem_cnt  = $urandom_range(0, 3);
      end
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rand_line();
        end else begin
          mem_cnt--;
        end
      end else if (!o_cmd && !o_any && $urandom_range(0, 9) == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
      end
    end
  endtask

  // ---------------- main sequence ----------------
  logic [LINE_W-1:0] line;

  initial begin
    rst = 1'b1;
    i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;

    @(negedge clk);
    chk_idle("reset");
    step();
    rst = 1'b0;

    // Single I read at 0x40, memory answers on the third serve cycle.
    i_pmem_read = 1; i_pmem_address = 32'h40;
    @(negedge clk);
    chk("d1_arb_latency", pmem_read, 0);
    step();
    @(negedge clk);
    chk("d1_pmem_read", pmem_read, 1);
    chk("d1_pmem_addr", pmem_address, 32'h40);
    chk("d1_pmem_write", pmem_write, 0);
    step();
    step();
    line = rand_line(); pmem_rdata = line; pmem_resp = 1;
    @(negedge clk);
    chk("d1_i_resp", i_pmem_resp, 1);
    chk("d1_i_rdata", i_pmem_rdata, line);
    chk("d1_d_resp", d_pmem_resp, 0);
    step();
    pmem_resp = 0; i_pmem_read = 0;
    @(negedge clk);
    chk_idle("d1_after");

    // Reset, then simultaneous I read and D write: D first, bubble, then I.
    rst = 1;
    #1;
    chk_idle("d2_rst");
    step();
    rst = 0;
    i_pmem_read = 1; i_pmem_address = 32'h200;
    d_pmem_write = 1; d_pmem_address = 32'h100; d_pmem_wdata = {32{8'hA5}};
    step();
    @(negedge clk);
    chk("d2_d_write", pmem_write, 1);
    chk("d2_d_read", pmem_read, 0);
    chk("d2_d_addr", pmem_address, 32'h100);
    chk("d2_d_wdata", pmem_wdata, {32{8'hA5}});
    step();
    pmem_resp = 1; pmem_rdata = rand_line();
    @(negedge clk);
    chk("d2_d_resp", d_pmem_resp, 1);
    chk("d2_i_resp_held", i_pmem_resp, 0);
    step();
    pmem_resp = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    @(negedge clk);
    chk("d2_bubble_read", pmem_read, 0);
    step();
    @(negedge clk);
    chk("d2_i_read", pmem_read, 1);
    chk("d2_i_addr", pmem_address, 32'h200);
    step();
    pmem_resp = 1;
    @(negedge clk);
    chk("d2_i_resp", i_pmem_resp, 1);
    step();
    pmem_resp = 0; i_pmem_address = 32'h300;
    d_pmem_read = 1; d_pmem_address = 32'h400;
    @(negedge clk);
    chk("d2_bubble2_read", pmem_read, 0);
    step();
    @(negedge clk);
    chk("d2_alternate_d_addr", pmem_address, 32'h400);

    // Reset in SERVE_D with a response in flight: everything drops at once.
    step();
    rst = 1; pmem_resp = 1;
    #1;
    chk_idle("d5_rst_mid");
    @(negedge clk);
    chk("d5_d_resp_held", d_pmem_resp, 0);
    step();
    rst = 0; pmem_resp = 0; i_pmem_read = 0; d_pmem_read = 0;
    @(negedge clk);
    chk_idle("d5_after");

    // Stray memory response while idle.
    step();
    pmem_resp = 1;
    @(negedge clk);
    chk_idle("d4_stray");
    step();
    pmem_resp = 0;
    line = rand_line();
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h500; d_pmem_wdata = line;
    @(negedge clk);
    chk("d4_still_idle", pmem_write, 0);

    // Client raising read and write together: write wins.
    step();
    @(negedge clk);
    chk("d6_write", pmem_write, 1);
    chk("d6_read", pmem_read, 0);
    chk("d6_wdata", pmem_wdata, line);
    step();
    pmem_resp = 1;
    @(negedge clk);
    chk("d6_d_resp", d_pmem_resp, 1);
    step();
    pmem_resp = 0; d_pmem_read = 0; d_pmem_write = 0;
    @(negedge clk);
    chk_idle("d6_after");

    // Randomized phase; D was served last.
    step();
    m_last_d = 1'b1;
    sb_on = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) rand_cycle(1'b1);
    for (int k = 0; k < 200 && (act_i || act_d); k++) rand_cycle(1'b0);
    chk("drain_clients_done", {act_i, act_d}, 0);
    repeat (3) @(negedge clk);
    chk("drain_queues_empty", q_i.size() + q_d.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameters SHALL be declared one per line as: name, default, meaning.
REQ-002 LINE_W, 256, cacheline width in bits.
REQ-003 ADDR_W, 32, physical address width in bits.
REQ-004 Ports SHALL be declared one per line as: name, direction, width, meaning; clock and reset SHALL come first.
REQ-005 clk  in  1  single clock for the block; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 i_pmem_read  in  1  I-cache line-read request.
REQ-008 i_pmem_write  in  1  I-cache line-write request.
REQ-009 i_pmem_address  in  ADDR_W  I-cache line address.
REQ-010 i_pmem_wdata  in  LINE_W  I-cache write line.
REQ-011 i_pmem_rdata  out  LINE_W  read line returned to the I-cache.
REQ-012 i_pmem_resp  out  1  I-cache transaction-done pulse.
REQ-013 d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata, d_pmem_rdata and d_pmem_resp SHALL match REQ-007 to REQ-012 in direction, width and meaning, serving the D-cache.
REQ-014 pmem_read  out  1  read command to shared physical memory.
REQ-015 pmem_write  out  1  write command to shared physical memory.
REQ-016 pmem_address  out  ADDR_W  address to shared physical memory.
REQ-017 pmem_wdata  out  LINE_W  write line to shared physical memory.
REQ-018 pmem_rdata  in  LINE_W  read line from shared physical memory.
REQ-019 pmem_resp  in  1  memory transaction-done pulse.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, SERVE_I and SERVE_D.
REQ-021 A client SHALL be requesting when its read OR write input is 1.
REQ-022 Arbitration in IDLE:
- Only one client requesting: that client SHALL be granted.
- Both requesting: the client not named by the last_served register SHALL be granted.
- Neither requesting: the FSM SHALL remain in IDLE.
REQ-023 A grant SHALL take effect on the next edge; pmem commands SHALL first assert in the SERVE cycle, giving 1 cycle of arbitration latency.
REQ-024 In IDLE, pmem_read, pmem_write, pmem_address, pmem_wdata and both client resp outputs SHALL be 0.
REQ-025 In SERVE_x, pmem_address and pmem_wdata SHALL combinationally follow client x.
- pmem_write SHALL equal x_pmem_write.
- pmem_read SHALL equal x_pmem_read AND NOT x_pmem_write, so write wins when both are asserted.
REQ-026 In SERVE_x, the non-granted client's resp SHALL be 0, and its request SHALL be held off without loss until a later grant.
REQ-027 In SERVE_x with pmem_resp=1:
- x_pmem_resp SHALL be 1 in the same cycle.
- The next state SHALL be IDLE.
- last_served SHALL update to x.
REQ-028 SERVE_x SHALL persist until pmem_resp, even if client x drops its request; there SHALL be no timeout.
REQ-029 At least one IDLE cycle SHALL occur between consecutive grants, so back-to-back transactions cost 1 bubble.
REQ-030 pmem_resp asserted in IDLE SHALL be ignored, with no client resp and no state change.
REQ-031 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata at all times; validity is qualified only by the respective resp.
REQ-032 Grant SHALL never switch mid-transaction; at most one client resp SHALL be high in any cycle.

Reset
REQ-033 rst=1 SHALL asynchronously force: state=IDLE, last_served=I, and all outputs per REQ-024.
- This SHALL apply even mid-transaction; any in-flight pmem_resp SHALL be dropped.
- After rst falls, the first simultaneous request SHALL therefore grant D.

Verification
REQ-034 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset then i_pmem_read=1 at address 0x0000_0040, memory responds after 3 cycles -> pmem_read=1 with pmem_address=0x40 from cycle 1; i_pmem_resp=1 for 1 cycle with i_pmem_rdata=pmem_rdata.
- Reset, then I read and D write issued in the same cycle -> D served first with pmem_write=1; then 1 IDLE cycle; then I served; then, if both request again, D is granted (alternation).
- d_pmem_write=1 at address 0x100 with wdata 256'hA5..A5 -> pmem_write=1, pmem_wdata=A5..A5, pmem_read=0.
- pmem_resp pulsed while in IDLE -> no client resp and the FSM stays in IDLE.
- rst asserted during SERVE_D before pmem_resp -> all outputs 0 immediately, FSM in IDLE, d_pmem_resp never pulses.
- Client holding both read=1 and write=1 -> pmem_write=1 and pmem_read=0.
